non_restoring_division_controller: RTL and testbench

- Control FSM that drives the 16-bit non-restoring division datapath.
- Accepts a start request and sequences the operand load, 16 shift/add-or-subtract iterations, the optional final remainder correction, and the result-register load.
- Reports busy and done, and sits directly beside the datapath, driving every datapath control input.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_iter_counter.sv | 38 +++
 rtl/non_restoring_division_controller.sv | 133 +++++++++++++
 tb/tb_non_restoring_division_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the 16-bit non-restoring divider controller.
// State encoding is fixed at 3 bits so the datapath side can decode it if needed.
package div_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [2:0] {
    DIV_STATE_IDLE    = 3'd0,
    DIV_STATE_LOAD    = 3'd1,
    DIV_STATE_ITER    = 3'd2,
    DIV_STATE_CHECK   = 3'd3,
    DIV_STATE_CORRECT = 3'd4,
    DIV_STATE_STORE   = 3'd5,
    DIV_STATE_DONE    = 3'd6
  } div_state_e;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter: synchronous clear, enable-gated increment that saturates at WIDTH.
// last is high while the count sits on the final iteration (WIDTH-1).
module div_iter_counter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_LAST);

endmodule

// File: rtl/non_restoring_division_controller.sv
// Control FSM for the non-restoring divider: LOAD, WIDTH shift/add-sub steps, optional remainder fix, STORE, DONE.
// Outputs decode from state only. DIV_ZERO_CHECK_EN adds a divide-by-zero shortcut and error flag.
module non_restoring_division_controller
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic a_negative,
  input  logic divisor_zero,
  output logic select_A,
  output logic select_Q,
  output logic ld_A,
  output logic ld_Q,
  output logic shift_left_enable_a,
  output logic shift_left_enable_q,
  output logic select_add,
  output logic count_enable,
  output logic ld_rem_quotient,
  output logic busy,
  output logic done,
  output logic error
);

  div_state_e state_q, state_d;
  logic       error_q, error_d;
  logic       cnt_last;
  logic       cnt_clr;

`ifndef DIV_ZERO_CHECK_EN
  logic       divisor_zero_unused;
  assign divisor_zero_unused = divisor_zero;
`endif

  assign cnt_clr = (state_q == DIV_STATE_LOAD);

  div_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (count_enable),
    .last (cnt_last)
  );

  always_comb begin
    state_d             = state_q;
    error_d             = error_q;
    select_A            = 1'b0;
    select_Q            = 1'b0;
    ld_A                = 1'b0;
    ld_Q                = 1'b0;
    shift_left_enable_a = 1'b0;
    shift_left_enable_q = 1'b0;
    select_add          = 1'b0;
    count_enable        = 1'b0;
    ld_rem_quotient     = 1'b0;
    done                = 1'b0;
    busy                = (state_q != DIV_STATE_IDLE);

    case (state_q)
      DIV_STATE_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          state_d = DIV_STATE_LOAD;
`ifdef DIV_ZERO_CHECK_EN
          // Skip the datapath entirely so A/Q/result keep their old contents.
          if (divisor_zero) begin
            error_d = 1'b1;
            state_d = DIV_STATE_DONE;
          end
`endif
        end
      end
      DIV_STATE_LOAD: begin
        ld_A    = 1'b1;
        ld_Q    = 1'b1;
        state_d = DIV_STATE_ITER;
      end
      DIV_STATE_ITER: begin
        ld_A                = 1'b1;
        ld_Q                = 1'b1;
        select_A            = 1'b1;
        select_Q            = 1'b1;
        shift_left_enable_a = 1'b1;
        shift_left_enable_q = 1'b1;
        select_add          = 1'b1;
        count_enable        = 1'b1;
        if (cnt_last) begin
          state_d = DIV_STATE_CHECK;
        end
      end
      DIV_STATE_CHECK: begin
        state_d = a_negative ? DIV_STATE_CORRECT : DIV_STATE_STORE;
      end
      DIV_STATE_CORRECT: begin
        // Add the divisor back onto the unshifted negative remainder.
        ld_A     = 1'b1;
        select_A = 1'b1;
        state_d  = DIV_STATE_STORE;
      end
      DIV_STATE_STORE: begin
        ld_rem_quotient = 1'b1;
        state_d         = DIV_STATE_DONE;
      end
      DIV_STATE_DONE: begin
        done    = 1'b1;
        state_d = DIV_STATE_IDLE;
      end
      default: begin
        state_d = DIV_STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_STATE_IDLE;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;

endmodule

// File: tb/tb_non_restoring_division_controller.sv
// Directed bench for the divider controller: per-cycle control tables plus a small
// behavioural datapath that checks 100 / 7 end to end.
module tb_non_restoring_division_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic a_neg_tb = 1'b0;
  logic divisor_zero = 1'b0;
  logic use_dp = 1'b0;
  logic a_negative;

  logic select_A, select_Q, ld_A, ld_Q, shift_left_enable_a, shift_left_enable_q;
  logic select_add, count_enable, ld_rem_quotient, busy, done, error;

  always #5 clk = ~clk;

  non_restoring_division_controller dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .a_negative          (a_negative),
    .divisor_zero        (divisor_zero),
    .select_A            (select_A),
    .select_Q            (select_Q),
    .ld_A                (ld_A),
    .ld_Q                (ld_Q),
    .shift_left_enable_a (shift_left_enable_a),
    .shift_left_enable_q (shift_left_enable_q),
    .select_add          (select_add),
    .count_enable        (count_enable),
    .ld_rem_quotient     (ld_rem_quotient),
    .busy                (busy),
    .done                (done),
    .error               (error)
  );

  // {selA selQ ldA ldQ shA shQ selAdd cnt ldRQ busy done err}
  logic [11:0] outs;
  assign outs = {select_A, select_Q, ld_A, ld_Q, shift_left_enable_a, shift_left_enable_q,
                 select_add, count_enable, ld_rem_quotient, busy, done, error};

  localparam logic [11:0] O_IDLE  = 12'b0000_0000_0000;
  localparam logic [11:0] O_LOAD  = 12'b0011_0000_0100;
  localparam logic [11:0] O_ITER  = 12'b1111_1111_0100;
  localparam logic [11:0] O_CHECK = 12'b0000_0000_0100;
  localparam logic [11:0] O_CORR  = 12'b1010_0000_0100;
  localparam logic [11:0] O_STORE = 12'b0000_0000_1100;
  localparam logic [11:0] O_DONE  = 12'b0000_0000_0110;

  // Behavioural datapath driven by the controller outputs.
  logic [16:0] dp_a, dp_sh, dp_sum;
  logic [15:0] dp_q, dp_m, dp_dvd, rem_r, quo_r;
  assign dp_sh  = {dp_a[15:0], dp_q[15]};
  assign dp_sum = dp_a[16] ? dp_sh + {1'b0, dp_m} : dp_sh - {1'b0, dp_m};
  assign a_negative = use_dp ? dp_a[16] : a_neg_tb;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_a  <= '0;
      dp_q  <= '0;
      rem_r <= '0;
      quo_r <= '0;
    end else begin
      if (ld_A) dp_a <= !select_A ? 17'd0 : (select_add ? dp_sum : dp_a + {1'b0, dp_m});
      if (ld_Q) dp_q <= select_Q ? {dp_q[14:0], ~dp_sum[16]} : dp_dvd;
      if (ld_rem_quotient) begin
        rem_r <= dp_a[15:0];
        quo_r <= dp_q;
      end
    end
  end

  int done_cnt = 0;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        start;
    logic        a_neg;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[0:23];

  task automatic fill(input logic corr);
    int s;
    for (int i = 0; i < 24; i++) begin
      tbl[i].start = 1'b0;
      tbl[i].a_neg = 1'b0;
      tbl[i].exp   = O_IDLE;
    end
    tbl[0].start = 1'b1;
    tbl[1].exp   = O_LOAD;
    for (int i = 2; i < 18; i++) begin
      tbl[i].exp   = O_ITER;
      tbl[i].a_neg = 1'b1;
    end
    tbl[5].start  = 1'b1;
    tbl[18].exp   = O_CHECK;
    tbl[18].a_neg = corr;
    s = 19;
    if (corr) begin
      tbl[19].exp = O_CORR;
      s = 20;
    end
    tbl[s].exp       = O_STORE;
    tbl[s + 1].exp   = O_DONE;
    tbl[s + 1].start = 1'b1;
    tbl[20].start    = 1'b1;
  endtask

  task automatic run_tbl(input string nm);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      chk($sformatf("%s cyc%0d", nm, i), {20'd0, outs}, {20'd0, tbl[i].exp});
      start    = tbl[i].start;
      a_neg_tb = tbl[i].a_neg;
    end
    start = 1'b0;
    chk({nm, " done pulses"}, done_cnt - d0, 1);
  endtask

  // Call just after a negedge with start already driven; returns cycles to done or -1.
  task automatic wait_done(input logic hold, output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat, lat2, d0;

  initial begin
    dp_m   = 16'd7;
    dp_dvd = 16'd100;

    // Reset held with start high.
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset outs %0d", i), {20'd0, outs}, {20'd0, O_IDLE});
    end
    rst = 1'b1;
    @(negedge clk);
    chk("first LOAD after reset", {20'd0, outs}, {20'd0, O_LOAD});
    wait_done(1'b0, lat);
    chk("drain after reset", lat, 19);
    @(negedge clk);

    fill(1'b0);
    run_tbl("nominal");
    fill(1'b1);
    run_tbl("correct");

    // Full division through the behavioural datapath.
    use_dp = 1'b1;
    @(negedge clk);
    start = 1'b1;
    wait_done(1'b0, lat);
    chk("100/7 latency", lat, 21);
    chk("100/7 quotient", {16'd0, quo_r}, 32'd14);
    chk("100/7 remainder", {16'd0, rem_r}, 32'd2);
    use_dp = 1'b0;

    // Reset dropped mid-iteration.
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("iter8 before reset", {20'd0, outs}, {20'd0, O_ITER});
    d0 = done_cnt;
    #2 rst = 1'b0;
    #1 chk("outs after async reset", {20'd0, outs}, {20'd0, O_IDLE});
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("no done after abort", done_cnt - d0, 0);
    @(negedge clk);
    start = 1'b1;
    wait_done(1'b0, lat);
    chk("restart latency", lat, 20);

    // Level-held start relaunches one idle cycle after DONE.
    @(negedge clk);
    start = 1'b1;
    wait_done(1'b1, lat);
    wait_done(1'b1, lat2);
    start = 1'b0;
    chk("held start first", lat, 20);
    chk("held start relaunch", lat2, 21);
    @(negedge clk);
    chk("idle after held", {20'd0, outs}, {20'd0, O_IDLE});

    // Zero divisor.
    @(negedge clk);
    divisor_zero = 1'b1;
    start = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
    @(negedge clk);
    start = 1'b0;
    chk("div0 done+error", {20'd0, outs}, {20'd0, O_DONE | 12'h001});
    @(negedge clk);
    chk("div0 error held", {20'd0, outs}, {20'd0, 12'h001});
    divisor_zero = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("error cleared on start", {20'd0, outs}, {20'd0, O_LOAD});
    wait_done(1'b0, lat);
    chk("post-div0 latency", lat, 19);
`else
    wait_done(1'b0, lat);
    chk("div0 ignored latency", lat, 20);
    chk("div0 error low", {31'd0, error}, 32'd0);
    divisor_zero = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
